status_reg: RTL and testbench

Processor status (P) register for the 6502 core, directly downstream of the ALU. It captures the ALU's registered N/V/Z/C flags under a per-flag write mask, and executes the flag instructions (CLC/SEC/CLI/SEI/CLV/CLD/SED). It also loads P from the data bus for PLP/RTI, forms the push byte for PHP/BRK/IRQ/NMI, and handles the SO pin. It feeds the carry back to the ALU and the interrupt mask to the interrupt sequencer.

---
 rtl/status_reg.sv | 125 ++++++++++++
 tb/tb_status_reg.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/status_reg.sv
// 6502 processor status (P) register: ALU flag capture, flag instructions, PLP/RTI load,
// push byte formation and SO pin. Optional macro STATUS_IRQ_DELAY_EN adds one-edge irq_mask lag.
module status_reg (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] alu_status,
  input  logic       upd_en,
  input  logic [7:0] upd_mask,
  input  logic [2:0] flag_op,
  input  logic       ld_en,
  input  logic [7:0] ld_data,
  input  logic       int_entry,
  input  logic       push_brk,
  input  logic       so_n,
  output logic [7:0] p,
  output logic [7:0] push_data,
  output logic       carry,
  output logic       decimal,
  output logic       irq_mask
);

  localparam logic [2:0] OP_CLC = 3'd1;
  localparam logic [2:0] OP_SEC = 3'd2;
  localparam logic [2:0] OP_CLI = 3'd3;
  localparam logic [2:0] OP_SEI = 3'd4;
  localparam logic [2:0] OP_CLV = 3'd5;
  localparam logic [2:0] OP_CLD = 3'd6;
  localparam logic [2:0] OP_SED = 3'd7;

  logic n_q, v_q, d_q, i_q, z_q, c_q;
  logic n_d, v_d, d_d, i_d, z_d, c_d;
  logic s1_q, s2_q, s3_q;
  logic so_fall;

  // Bits 5..2 of the flag/mask bytes and 5..4 of the load byte carry no state.
  logic unused_bits;
  assign unused_bits = ^{alu_status[5:2], upd_mask[5:2], ld_data[5:4]};

  assign so_fall = s3_q & ~s2_q;

  // Per-flag next value; each later source overrides the earlier ones.
  always_comb begin
    n_d = n_q;
    v_d = v_q;
    d_d = d_q;
    i_d = i_q;
    z_d = z_q;
    c_d = c_q;

    case (flag_op)
      OP_CLC:  c_d = 1'b0;
      OP_SEC:  c_d = 1'b1;
      OP_CLI:  i_d = 1'b0;
      OP_SEI:  i_d = 1'b1;
      OP_CLV:  v_d = 1'b0;
      OP_CLD:  d_d = 1'b0;
      OP_SED:  d_d = 1'b1;
      default: ;
    endcase

    if (upd_en) begin
      if (upd_mask[7]) n_d = alu_status[7];
      if (upd_mask[6]) v_d = alu_status[6];
      if (upd_mask[1]) z_d = alu_status[1];
      if (upd_mask[0]) c_d = alu_status[0];
    end

    if (ld_en) begin
      n_d = ld_data[7];
      v_d = ld_data[6];
      d_d = ld_data[3];
      i_d = ld_data[2];
      z_d = ld_data[1];
      c_d = ld_data[0];
    end

    if (so_fall)   v_d = 1'b1;
    if (int_entry) i_d = 1'b1;
  end

  // Flag storage plus SO synchronizer and edge-history flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      n_q  <= 1'b0;
      v_q  <= 1'b0;
      d_q  <= 1'b0;
      i_q  <= 1'b1;
      z_q  <= 1'b0;
      c_q  <= 1'b0;
      s1_q <= 1'b1;
      s2_q <= 1'b1;
      s3_q <= 1'b1;
    end else begin
      n_q  <= n_d;
      v_q  <= v_d;
      d_q  <= d_d;
      i_q  <= i_d;
      z_q  <= z_d;
      c_q  <= c_d;
      s1_q <= so_n;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign p         = {n_q, v_q, 1'b1, 1'b0, d_q, i_q, z_q, c_q};
  assign push_data = {n_q, v_q, 1'b1, push_brk, d_q, i_q, z_q, c_q};
  assign carry     = c_q;
  assign decimal   = d_q;

`ifdef STATUS_IRQ_DELAY_EN
  // Mask trails I by one edge, except interrupt entry sets it alongside I.
  logic irq_mask_q;

  always_ff @(posedge clk) begin
    if (rst) irq_mask_q <= 1'b1;
    else     irq_mask_q <= int_entry | i_q;
  end

  assign irq_mask = irq_mask_q;
`else
  assign irq_mask = i_q;
`endif

endmodule

// File: tb/tb_status_reg.sv
// Scoreboard bench for status_reg: expectations are queued with the edge they apply to
// and compared #1 after that edge.
module tb_status_reg;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] alu_status;
  logic       upd_en;
  logic [7:0] upd_mask;
  logic [2:0] flag_op;
  logic       ld_en;
  logic [7:0] ld_data;
  logic       int_entry;
  logic       push_brk;
  logic       so_n;
  logic [7:0] p;
  logic [7:0] push_data;
  logic       carry;
  logic       decimal;
  logic       irq_mask;

`ifdef STATUS_IRQ_DELAY_EN
  localparam bit DLY = 1'b1;
`else
  localparam bit DLY = 1'b0;
`endif

  localparam int SEL_P    = 0;
  localparam int SEL_PUSH = 1;
  localparam int SEL_C    = 2;
  localparam int SEL_D    = 3;
  localparam int SEL_IRQ  = 4;

  status_reg dut (
    .clk       (clk),
    .rst       (rst),
    .alu_status(alu_status),
    .upd_en    (upd_en),
    .upd_mask  (upd_mask),
    .flag_op   (flag_op),
    .ld_en     (ld_en),
    .ld_data   (ld_data),
    .int_entry (int_entry),
    .push_brk  (push_brk),
    .so_n      (so_n),
    .p         (p),
    .push_data (push_data),
    .carry     (carry),
    .decimal   (decimal),
    .irq_mask  (irq_mask)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  int         q_cyc[$];
  int         q_sel[$];
  string      q_tag[$];
  logic [7:0] q_exp[$];

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (edge %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic expect_at(input int dly, input int sel, input string tag, input logic [7:0] v);
    q_cyc.push_back(cyc + dly);
    q_sel.push_back(sel);
    q_tag.push_back(tag);
    q_exp.push_back(v);
  endtask

  function automatic logic [7:0] observe(input int sel);
    case (sel)
      SEL_P:    return p;
      SEL_PUSH: return push_data;
      SEL_C:    return {7'd0, carry};
      SEL_D:    return {7'd0, decimal};
      default:  return {7'd0, irq_mask};
    endcase
  endfunction

  // Compare every expectation due at this edge.
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      while (q_cyc.size() > 0 && q_cyc[0] <= cyc) begin
        int         s;
        string      t;
        logic [7:0] e;
        void'(q_cyc.pop_front());
        s = q_sel.pop_front();
        t = q_tag.pop_front();
        e = q_exp.pop_front();
        chk(t, observe(s), e);
      end
    end
  end

  task automatic nxt();
    @(negedge clk);
    rst        = 1'b0;
    alu_status = 8'h00;
    upd_en     = 1'b0;
    upd_mask   = 8'h00;
    flag_op    = 3'd0;
    ld_en      = 1'b0;
    ld_data    = 8'h00;
    int_entry  = 1'b0;
  endtask

  initial begin
    rst = 1'b1; alu_status = 8'h00; upd_en = 1'b0; upd_mask = 8'h00; flag_op = 3'd0;
    ld_en = 1'b0; ld_data = 8'h00; int_entry = 1'b0; push_brk = 1'b1; so_n = 1'b1;
    repeat (2) @(posedge clk);

    nxt();
    expect_at(1, SEL_P, "rst_p", 8'h24);
    expect_at(1, SEL_PUSH, "rst_push", 8'h34);
    expect_at(1, SEL_IRQ, "rst_irq", 8'h01);
    expect_at(1, SEL_C, "rst_carry", 8'h00);

    nxt(); alu_status = 8'hFF; upd_mask = 8'hFF;
    expect_at(1, SEL_P, "upd_off", 8'h24);

    nxt(); upd_en = 1'b1; alu_status = 8'hC3; upd_mask = 8'h81;
    expect_at(1, SEL_P, "masked_upd", 8'hA5);
    expect_at(1, SEL_C, "masked_carry", 8'h01);

    nxt(); upd_en = 1'b1; alu_status = 8'h3C; upd_mask = 8'hFF;
    expect_at(1, SEL_P, "upd_ignored_bits", 8'h24);
    expect_at(1, SEL_C, "upd_carry_clr", 8'h00);

    nxt(); flag_op = 3'd2;
    expect_at(1, SEL_P, "sec", 8'h25);
    expect_at(1, SEL_C, "sec_carry", 8'h01);
    nxt(); flag_op = 3'd7;
    expect_at(1, SEL_P, "sed", 8'h2D);
    expect_at(1, SEL_D, "sed_decimal", 8'h01);
    nxt(); flag_op = 3'd6;
    expect_at(1, SEL_P, "cld", 8'h25);
    expect_at(1, SEL_D, "cld_decimal", 8'h00);
    nxt(); flag_op = 3'd1;
    expect_at(1, SEL_P, "clc", 8'h24);
    nxt(); upd_en = 1'b1; alu_status = 8'h40; upd_mask = 8'h40;
    expect_at(1, SEL_P, "upd_v", 8'h64);
    nxt(); flag_op = 3'd5;
    expect_at(1, SEL_P, "clv", 8'h24);

    nxt(); flag_op = 3'd7; upd_en = 1'b1; alu_status = 8'h01; upd_mask = 8'h01;
    expect_at(1, SEL_P, "disjoint_set", 8'h2D);
    nxt(); flag_op = 3'd6; upd_en = 1'b1; alu_status = 8'h00; upd_mask = 8'h01;
    expect_at(1, SEL_P, "disjoint_clr", 8'h24);

    nxt(); flag_op = 3'd2; upd_en = 1'b1; upd_mask = 8'h01; ld_en = 1'b1; ld_data = 8'h01;
    expect_at(1, SEL_P, "prio_ld", 8'h21);
    expect_at(1, SEL_C, "prio_ld_carry", 8'h01);
    nxt(); flag_op = 3'd2; upd_en = 1'b1; upd_mask = 8'h01; ld_en = 1'b1; ld_data = 8'h01;
    int_entry = 1'b1;
    expect_at(1, SEL_P, "prio_int", 8'h25);
    expect_at(1, SEL_IRQ, "prio_int_irq", 8'h01);
    nxt(); ld_en = 1'b1; ld_data = 8'h24;
    expect_at(1, SEL_P, "ld_restore", 8'h24);

    nxt(); flag_op = 3'd3;
    expect_at(1, SEL_P, "cli", 8'h20);
    expect_at(1, SEL_IRQ, "cli_irq_k", DLY ? 8'h01 : 8'h00);
    nxt();
    expect_at(1, SEL_IRQ, "cli_irq_k1", 8'h00);
    nxt(); flag_op = 3'd4;
    expect_at(1, SEL_P, "sei", 8'h24);
    expect_at(1, SEL_IRQ, "sei_irq_k", DLY ? 8'h00 : 8'h01);
    nxt();
    expect_at(1, SEL_IRQ, "sei_irq_k1", 8'h01);
    nxt(); flag_op = 3'd3;
    expect_at(1, SEL_P, "cli2", 8'h20);
    nxt();
    expect_at(1, SEL_IRQ, "cli2_irq", 8'h00);
    nxt(); int_entry = 1'b1;
    expect_at(1, SEL_P, "int_entry", 8'h24);
    expect_at(1, SEL_IRQ, "int_entry_irq", 8'h01);

    nxt(); so_n = 1'b0;
    expect_at(1, SEL_P, "so_e0", 8'h24);
    expect_at(2, SEL_P, "so_e1", 8'h24);
    expect_at(3, SEL_P, "so_e2", 8'h64);
    nxt();
    nxt();
    nxt(); flag_op = 3'd5;
    expect_at(1, SEL_P, "so_clv", 8'h24);
    nxt();
    expect_at(1, SEL_P, "so_held_low", 8'h24);
    nxt(); so_n = 1'b1;
    expect_at(1, SEL_P, "so_release", 8'h24);
    nxt();
    nxt();
    nxt(); so_n = 1'b0;
    expect_at(2, SEL_P, "so_rearm_e1", 8'h24);
    expect_at(3, SEL_P, "so_rearm", 8'h64);
    nxt();
    nxt();
    nxt(); so_n = 1'b1;

    nxt(); ld_en = 1'b1; ld_data = 8'hFF; push_brk = 1'b0;
    expect_at(1, SEL_P, "plp_ff", 8'hEF);
    expect_at(1, SEL_D, "plp_decimal", 8'h01);
    expect_at(1, SEL_C, "plp_carry", 8'h01);
    expect_at(1, SEL_PUSH, "plp_push", 8'hEF);
    expect_at(1, SEL_IRQ, "plp_irq", 8'h01);
    nxt(); ld_en = 1'b1; ld_data = 8'h00; push_brk = 1'b1;
    expect_at(1, SEL_P, "plp_00", 8'h20);
    expect_at(1, SEL_PUSH, "plp_00_push", 8'h30);
    expect_at(1, SEL_IRQ, "plp_00_irq_k", DLY ? 8'h01 : 8'h00);
    nxt();
    expect_at(1, SEL_IRQ, "plp_00_irq_k1", 8'h00);

    nxt(); rst = 1'b1; ld_en = 1'b1; ld_data = 8'hFF; flag_op = 3'd7; upd_en = 1'b1;
    alu_status = 8'hFF; upd_mask = 8'hFF;
    expect_at(1, SEL_P, "rst_wins", 8'h24);
    expect_at(1, SEL_IRQ, "rst_wins_irq", 8'h01);
    expect_at(1, SEL_PUSH, "rst_wins_push", 8'h34);
    nxt();
    expect_at(1, SEL_P, "post_rst", 8'h24);

    for (int k = 0; k < 20 && q_cyc.size() > 0; k++) @(negedge clk);
    chk("drain", 8'(q_cyc.size()), 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
